// File: rtl/iterative_alu.sv
// Multi-cycle RV32I ALU: single-cycle logic ops, bit-serial shifts (one bit per cycle),
// valid/ready handshakes on both the operand side and the result side.
module iterative_alu #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_control,
   input  logic [XLEN-1:0]    src_a,
   input  logic [XLEN-1:0]    src_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    result,
   output logic               zero,
   output logic               illegal
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_SRL = 4'b0111;
   localparam logic [3:0] OP_SRA = 4'b1000;

   state_t              state_q, state_d;
   logic [3:0]          op_q, op_d;
   logic [XLEN-1:0]     acc_q, acc_d;
   logic [SHAMT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                zero_q, zero_d;
   logic                illegal_q, illegal_d;

   logic [SHAMT_W-1:0]  shamt;
   logic                is_shift;
   logic                is_illegal;
   logic [XLEN-1:0]     op_result;
   logic [XLEN-1:0]     shift_next;

   assign shamt      = src_b[SHAMT_W-1:0];
   assign is_shift   = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                       (alu_control == OP_SRA);
   assign is_illegal = (alu_control > OP_SRA);

   // Single-cycle result; a shift only lands here when its amount is zero.
   always_comb begin
      op_result = '0;
      case (alu_control)
         OP_ADD:  op_result = src_a + src_b;
         OP_SUB:  op_result = src_a - src_b;
         OP_AND:  op_result = src_a & src_b;
         OP_OR:   op_result = src_a | src_b;
         OP_XOR:  op_result = src_a ^ src_b;
         OP_SLT:  op_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLL,
         OP_SRL,
         OP_SRA:  op_result = src_a;
         default: op_result = '0;
      endcase
   end

   always_comb begin
      case (op_q)
         OP_SLL:  shift_next = {acc_q[XLEN-2:0], 1'b0};
         OP_SRL:  shift_next = {1'b0, acc_q[XLEN-1:1]};
         default: shift_next = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d = alu_control;
               if (is_illegal) begin
                  result_d  = '0;
                  zero_d    = 1'b1;
                  illegal_d = 1'b1;
                  state_d   = DONE;
               end else if (is_shift && (shamt != '0)) begin
                  acc_d     = src_a;
                  cnt_d     = shamt;
                  illegal_d = 1'b0;
                  state_d   = SHIFT;
               end else begin
                  result_d  = op_result;
                  zero_d    = (op_result == '0);
                  illegal_d = 1'b0;
                  state_d   = DONE;
               end
            end
         end
         SHIFT: begin
            acc_d = shift_next;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = shift_next;
               zero_d   = (shift_next == '0);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule
